// File: rtl/surf_pkg.sv
// Shared encodings for the surfer physics block: FSM states, sprite frame
// codes and the velocity register width.
package surf_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GROUND = 2'd1,
    S_AIR    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CF_STILL = 2'd0,
    CF_RISE  = 2'd1,
    CF_FALL  = 2'd2
  } frame_e;

  localparam int VEL_W = 6;

endpackage

// File: rtl/frame_tick.sv
// Frame tick generator: registered rising-edge detector on the VGA vsync
// level, producing a single-cycle tick once per frame.
module frame_tick (
  input  logic clock,
  input  logic reset_n,
  input  logic vsync,
  output logic tick
);

  logic vsync_q, vsync_d;
  logic tick_q, tick_d;

  // Next-state: remember last vsync level, flag a low-to-high transition.
  always_comb begin
    vsync_d = vsync;
    tick_d  = vsync & ~vsync_q;
  end

  // Edge-detect registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/surfer_physics.sv
// Surfer physics: tracks the wave surface once per frame, launches into a
// ballistic arc when the wave drops away steeply, and lands back on it.
// Optional build macro SURF_JUMP_EN adds a player jump from the ground.
module surfer_physics
  import surf_pkg::*;
#(
  parameter int CHAR_HEIGHT = 20,
  parameter int START_VPOS  = 384,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 12,
  parameter int DROP_THRESH = 4,
  parameter int JUMP_V      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       play,
  input  logic [9:0] wave_height,
  input  logic       wave_ready,
  input  logic       jump,
  output logic [9:0] p_vpos,
  output logic [1:0] char_frame,
  output logic       airborne,
  output logic       landed
);

  logic tick;

  frame_tick u_frame_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .vsync  (vsync),
    .tick   (tick)
  );

  state_e                    state_q, state_d;
  logic        [9:0]         p_vpos_q, p_vpos_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic        [4:0]         last_rise_q, last_rise_d;
  logic        [9:0]         wave_q, wave_d;
  logic        [1:0]         char_frame_q, char_frame_d;
  logic                      airborne_q, airborne_d;
  logic                      landed_q, landed_d;

  logic        [9:0]         target;
  logic signed [11:0]        rise;
  logic                      drop;
  logic signed [VEL_W:0]     vel_inc;
  logic signed [VEL_W-1:0]   vel_fall;
  logic signed [11:0]        next_air;
  logic signed [VEL_W-1:0]   vel_launch;
  logic signed [11:0]        launch_pos;

  // Negative positions hit the top of the screen.
  function automatic logic [9:0] clamp_pos(input logic signed [11:0] v);
    if (v < 0) clamp_pos = '0;
    else       clamp_pos = v[9:0];
  endfunction

  // Remembered climb rate is kept in 0..31 so its negation fits VEL_W.
  function automatic logic [4:0] clamp_rise(input logic signed [11:0] v);
    if (v < 0)                    clamp_rise = '0;
    else if (v > 12'sd31)         clamp_rise = 5'd31;
    else                          clamp_rise = v[4:0];
  endfunction

  // Derived per-frame quantities from the registered state.
  always_comb begin
    target     = (wave_q < 10'(CHAR_HEIGHT)) ? '0 : wave_q - 10'(CHAR_HEIGHT);
    rise       = $signed({2'b00, p_vpos_q}) - $signed({2'b00, target});
    drop       = {1'b0, target} > ({1'b0, p_vpos_q} + 11'(DROP_THRESH));
    vel_inc    = {vel_q[VEL_W-1], vel_q} + 7'(GRAVITY);
    vel_fall   = (vel_inc > $signed(7'(MAX_FALL))) ? 6'(MAX_FALL) : vel_inc[VEL_W-1:0];
    next_air   = $signed({2'b00, p_vpos_q}) + $signed({{6{vel_fall[VEL_W-1]}}, vel_fall});
    vel_launch = -$signed({1'b0, last_rise_q});
    launch_pos = $signed({2'b00, p_vpos_q}) + $signed({{6{vel_launch[VEL_W-1]}}, vel_launch});
  end

`ifndef SURF_JUMP_EN
  logic unused_jump;
  assign unused_jump = jump & (JUMP_V != 0);
`endif

  // Next-state and output logic; everything advances only on the frame tick
  // except leaving PLAY, which returns to IDLE immediately.
  always_comb begin
    state_d      = state_q;
    p_vpos_d     = p_vpos_q;
    vel_d        = vel_q;
    last_rise_d  = last_rise_q;
    char_frame_d = char_frame_q;
    airborne_d   = airborne_q;
    landed_d     = 1'b0;
    wave_d       = wave_ready ? wave_height : wave_q;

    if (!play) begin
      state_d      = S_IDLE;
      p_vpos_d     = 10'(START_VPOS);
      vel_d        = '0;
      last_rise_d  = '0;
      char_frame_d = CF_STILL;
      airborne_d   = 1'b0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_GROUND;
          p_vpos_d     = target;
          char_frame_d = CF_STILL;
        end
        S_GROUND: begin
          if (drop) begin
            // Wave fell away: carry the last climb rate upward.
            state_d      = S_AIR;
            vel_d        = vel_launch;
            p_vpos_d     = clamp_pos(launch_pos);
            airborne_d   = 1'b1;
            char_frame_d = (vel_launch < 0) ? CF_RISE : CF_FALL;
          end
`ifdef SURF_JUMP_EN
          else if (jump) begin
            state_d      = S_AIR;
            vel_d        = -6'(JUMP_V);
            p_vpos_d     = clamp_pos($signed({2'b00, p_vpos_q}) - 12'(JUMP_V));
            airborne_d   = 1'b1;
            char_frame_d = CF_RISE;
          end
`endif
          else begin
            p_vpos_d    = target;
            last_rise_d = clamp_rise(rise);
            if (target < p_vpos_q)      char_frame_d = CF_RISE;
            else if (target > p_vpos_q) char_frame_d = CF_FALL;
            else                        char_frame_d = CF_STILL;
          end
        end
        S_AIR: begin
          // Velocity is updated first, then applied to the position.
          vel_d        = vel_fall;
          char_frame_d = (vel_fall < 0) ? CF_RISE : CF_FALL;
          if (next_air >= $signed({2'b00, target})) begin
            state_d     = S_GROUND;
            p_vpos_d    = target;
            vel_d       = '0;
            last_rise_d = '0;
            landed_d    = 1'b1;
            airborne_d  = 1'b0;
          end else if (next_air < 0) begin
            p_vpos_d = '0;
            vel_d    = '0;
          end else begin
            p_vpos_d = next_air[9:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      p_vpos_q     <= 10'(START_VPOS);
      vel_q        <= '0;
      last_rise_q  <= '0;
      wave_q       <= 10'(START_VPOS + CHAR_HEIGHT);
      char_frame_q <= CF_STILL;
      airborne_q   <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_vpos_q     <= p_vpos_d;
      vel_q        <= vel_d;
      last_rise_q  <= last_rise_d;
      wave_q       <= wave_d;
      char_frame_q <= char_frame_d;
      airborne_q   <= airborne_d;
      landed_q     <= landed_d;
    end
  end

  assign p_vpos     = p_vpos_q;
  assign char_frame = char_frame_q;
  assign airborne   = airborne_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_surfer_physics.sv
// Directed bench for surfer_physics: wave tracking, drop launch arc,
// saturated long fall, coincident sample/tick, play abort, target clamp,
// and the jump option (expectations follow SURF_JUMP_EN).
module tb_surfer_physics;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b0;
  logic       play = 1'b0;
  logic [9:0] wave_height = '0;
  logic       wave_ready = 1'b0;
  logic       jump = 1'b0;
  logic [9:0] p_vpos;
  logic [1:0] char_frame;
  logic       airborne;
  logic       landed;

  int checks = 0;
  int failures = 0;

  surfer_physics dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .play       (play),
    .wave_height(wave_height),
    .wave_ready (wave_ready),
    .jump       (jump),
    .p_vpos     (p_vpos),
    .char_frame (char_frame),
    .airborne   (airborne),
    .landed     (landed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe a new wave sample outside of any tick.
  task automatic set_wave(input logic [9:0] h);
    wave_height = h;
    wave_ready  = 1'b1;
    @(negedge clock);
    wave_ready  = 1'b0;
    @(negedge clock);
  endtask

  // One vsync pulse; returns right after the outputs have updated.
  // With with_wave set, the sample strobe lands in the tick cycle.
  task automatic frame(input bit with_wave = 1'b0, input logic [9:0] h = '0);
    vsync = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
    if (with_wave) begin
      wave_height = h;
      wave_ready  = 1'b1;
    end
    @(negedge clock);
    wave_ready = 1'b0;
  endtask

  initial begin
    int arc [10];
    int mp;
    int mv;
    bit done;
    int jexp [3];

    arc = '{266, 263, 261, 260, 260, 261, 263, 266, 270, 275};
`ifdef SURF_JUMP_EN
    jexp = '{272, 265, 259};
`else
    jexp = '{280, 280, 280};
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_pvpos", p_vpos, 384);
    check("rst_frame", char_frame, 0);
    check("rst_air", airborne, 0);
    check("rst_landed", landed, 0);
    check("rst_wave_q", dut.wave_q, 404);
    check("rst_vel", int'(dut.vel_q), 0);
    check("rst_state", dut.state_q, 0);
    reset_n = 1'b1;
    @(negedge clock);
    play = 1'b1;

    // Settle on wave 300
    set_wave(10'd300);
    frame();
    frame();
    check("ground_pvpos", p_vpos, 280);
    check("ground_frame", char_frame, 0);
    check("ground_air", airborne, 0);

    // Wave rises by 5
    set_wave(10'd295);
    frame();
    check("rise_pvpos", p_vpos, 275);
    check("rise_frame", char_frame, 1);
    check("rise_last", dut.last_rise_q, 5);

    // Wave drops to 320: launch carrying -5
    set_wave(10'd320);
    frame();
    check("launch_air", airborne, 1);
    check("launch_vel", int'(dut.vel_q), -5);
    check("launch_pvpos", p_vpos, 270);
    check("launch_frame", char_frame, 1);
    set_wave(10'd300);
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("arc_pvpos_%0d", i), p_vpos, arc[i]);
      check($sformatf("arc_landed_%0d", i), landed, 0);
      if (i == 0) check("arc_frame_up", char_frame, 1);
      if (i == 5) check("arc_frame_down", char_frame, 2);
    end
    frame();
    check("land_pvpos", p_vpos, 280);
    check("land_pulse", landed, 1);
    check("land_air", airborne, 0);
    frame();
    check("post_land_pulse", landed, 0);
    check("post_land_pvpos", p_vpos, 280);

    // Large rise clamps last_rise; then level out at 100
    set_wave(10'd120);
    frame();
    check("climb_pvpos", p_vpos, 100);
    check("climb_last_clamp", dut.last_rise_q, 31);
    frame();
    check("level_last", dut.last_rise_q, 0);

    // Long fall to 680
    set_wave(10'd700);
    frame();
    check("fall_launch_pvpos", p_vpos, 100);
    check("fall_launch_frame", char_frame, 2);
    mp = 100;
    mv = 0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      frame();
      mv = (mv + 1 > 12) ? 12 : mv + 1;
      if (mp + mv >= 680) begin
        mp = 680;
        done = 1'b1;
      end else begin
        mp = mp + mv;
      end
      check($sformatf("fall_pvpos_%0d", i), p_vpos, mp);
      check($sformatf("fall_landed_%0d", i), landed, int'(done));
      if (!done) check($sformatf("fall_vel_%0d", i), int'(dut.vel_q), mv);
    end
    if (!done) check("fall_budget", 0, 1);
    check("fall_air_end", airborne, 0);

    // Sample strobe coincident with tick uses the old sample
    frame(1'b1, 10'd600);
    check("coinc_old_pvpos", p_vpos, 680);
    check("coinc_old_frame", char_frame, 0);
    frame();
    check("coinc_new_pvpos", p_vpos, 580);
    check("coinc_new_frame", char_frame, 1);

    // Launch with clamped -31 and abort mid-air
    set_wave(10'd700);
    frame();
    check("abort_launch_vel", int'(dut.vel_q), -31);
    check("abort_launch_pvpos", p_vpos, 549);
    check("abort_launch_air", airborne, 1);
    play = 1'b0;
    @(negedge clock);
    check("abort_pvpos", p_vpos, 384);
    check("abort_air", airborne, 0);
    check("abort_landed", landed, 0);
    check("abort_frame", char_frame, 0);
    check("abort_state", dut.state_q, 0);

    // Wave above CHAR_HEIGHT from the top clamps target to 0
    play = 1'b1;
    set_wave(10'd10);
    frame();
    check("clamp_pvpos", p_vpos, 0);

    // Jump from ground at 280
    play = 1'b0;
    @(negedge clock);
    play = 1'b1;
    set_wave(10'd300);
    frame();
    check("jump_base_pvpos", p_vpos, 280);
    jump = 1'b1;
    frame();
    jump = 1'b0;
    check("jump_pvpos_0", p_vpos, jexp[0]);
    frame();
    check("jump_pvpos_1", p_vpos, jexp[1]);
    frame();
    check("jump_pvpos_2", p_vpos, jexp[2]);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    check("areset_pvpos", p_vpos, 384);
    check("areset_air", airborne, 0);
    check("areset_landed", landed, 0);
    @(negedge clock);
    check("areset_landed_hold", landed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
